alu_exec_unit: RTL and testbench

//   Execute stage between the register-bank operand read and write-back.

---
 rtl/alu_exec_unit.sv | 242 ++++++++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// Execute stage: latches an op from the register bank, computes it
// (single-cycle ALU or iterative shift-add multiply), strobes the bank
// write port once and waits for the bank's acknowledge.
//
// Ports:
//   clk, reset          clock (rising edge), synchronous active-high reset
//   start, instr        launch request and opcode/immediate, taken in IDLE
//   data_A, data_B      operands from the register bank
//   wr_done             bank write acknowledge, honoured only in WAIT
//   data_result         result presented to the bank write port
//   rd_wr               one-cycle write strobe (high exactly in WRITE)
//   busy                high in every state except IDLE
//   op_done             one-cycle pulse after the bank acknowledged
//   carry, zero         flags of the last completed op
//   timeout_err         sticky, set when the acknowledge never arrives
module alu_exec_unit #(
   parameter int WIDTH        = 4,
   parameter int DONE_TIMEOUT = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [7:0]       instr,
   input  logic [WIDTH-1:0] data_A,
   input  logic [WIDTH-1:0] data_B,
   input  logic             wr_done,
   output logic [WIDTH-1:0] data_result,
   output logic             rd_wr,
   output logic             busy,
   output logic             op_done,
   output logic             carry,
   output logic             zero,
   output logic             timeout_err
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_EXEC  = 3'd1;
   localparam logic [2:0] S_MUL   = 3'd2;
   localparam logic [2:0] S_WRITE = 3'd3;
   localparam logic [2:0] S_WAIT  = 3'd4;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_NOT = 3'd1;
   localparam logic [2:0] OP_SHL = 3'd2;
   localparam logic [2:0] OP_SHR = 3'd3;
   localparam logic [2:0] OP_SUB = 3'd4;
   localparam logic [2:0] OP_MUL = 3'd5;
   localparam logic [2:0] OP_LDI = 3'd6;
   localparam logic [2:0] OP_INC = 3'd7;

   localparam int MCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int TCW = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;

   localparam logic [MCW-1:0] MCNT_LAST = MCW'(WIDTH - 1);
   localparam logic [TCW-1:0] TCNT_LAST = TCW'(DONE_TIMEOUT - 1);

   logic [2:0]         state_q, state_d;
   logic [2:0]         op_q, op_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [3:0]         imm_q, imm_d;
   logic [2*WIDTH-1:0] prod_q, prod_d;
   logic [MCW-1:0]     mcnt_q, mcnt_d;
   logic [TCW-1:0]     tcnt_q, tcnt_d;
   logic [WIDTH-1:0]   res_q, res_d;
   logic               carry_q, carry_d;
   logic               zero_q, zero_d;
   logic               rd_wr_q, rd_wr_d;
   logic               op_done_q, op_done_d;
   logic               err_q, err_d;

   logic [WIDTH-1:0]   alu_res;
   logic               alu_c;
   logic [WIDTH:0]     wide;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] prod_step;

   // Single-cycle ALU on the latched operands.
   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      wide    = '0;
      unique case (op_q)
         OP_ADD: begin
            wide    = {1'b0, a_q} + {1'b0, b_q};
            alu_res = wide[WIDTH-1:0];
            alu_c   = wide[WIDTH];
         end
         OP_NOT: begin
            alu_res = ~a_q;
         end
         OP_SHL: begin
            alu_res = {a_q[WIDTH-2:0], 1'b0};
            alu_c   = a_q[WIDTH-1];
         end
         OP_SHR: begin
            alu_res = {1'b0, a_q[WIDTH-1:1]};
            alu_c   = a_q[0];
         end
         OP_SUB: begin
            alu_res = a_q - b_q;
            alu_c   = (a_q < b_q);
         end
         OP_LDI: begin
            alu_res = WIDTH'(imm_q);
         end
         OP_INC: begin
            wide    = {1'b0, a_q} + (WIDTH+1)'(1);
            alu_res = wide[WIDTH-1:0];
            alu_c   = wide[WIDTH];
         end
         default: begin
            alu_res = '0;
            alu_c   = 1'b0;
         end
      endcase
   end

   // One shift-add step: the multiplier sits in the low half and is
   // consumed LSB first while partial sums accumulate in the high half.
   always_comb begin
      mul_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
              + (prod_q[0] ? {1'b0, a_q} : '0);
      prod_step = {mul_sum, prod_q[WIDTH-1:1]};
   end

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      a_d       = a_q;
      b_d       = b_q;
      imm_d     = imm_q;
      prod_d    = prod_q;
      mcnt_d    = mcnt_q;
      tcnt_d    = tcnt_q;
      res_d     = res_q;
      carry_d   = carry_q;
      zero_d    = zero_q;
      rd_wr_d   = 1'b0;
      op_done_d = 1'b0;
      err_d     = err_q;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               op_d   = instr[7:5];
               a_d    = data_A;
               b_d    = data_B;
               imm_d  = instr[3:0];
               prod_d = {{WIDTH{1'b0}}, data_B};
               mcnt_d = '0;
               if (instr[7:5] == OP_MUL) begin
                  state_d = S_MUL;
               end else begin
                  state_d = S_EXEC;
               end
            end
         end
         S_EXEC: begin
            res_d   = alu_res;
            carry_d = alu_c;
            zero_d  = (alu_res == '0);
            rd_wr_d = 1'b1;
            state_d = S_WRITE;
         end
         S_MUL: begin
            prod_d = prod_step;
            mcnt_d = mcnt_q + MCW'(1);
            // Result is taken from the final step directly so the
            // MUL state lasts exactly WIDTH cycles.
            if (mcnt_q == MCNT_LAST) begin
               res_d   = prod_step[WIDTH-1:0];
               carry_d = |prod_step[2*WIDTH-1:WIDTH];
               zero_d  = (prod_step[WIDTH-1:0] == '0);
               rd_wr_d = 1'b1;
               state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            tcnt_d  = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (wr_done) begin
               op_done_d = 1'b1;
               state_d   = S_IDLE;
            end else if (tcnt_q == TCNT_LAST) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else begin
               tcnt_d = tcnt_q + TCW'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         op_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         imm_q     <= '0;
         prod_q    <= '0;
         mcnt_q    <= '0;
         tcnt_q    <= '0;
         res_q     <= '0;
         carry_q   <= 1'b0;
         zero_q    <= 1'b0;
         rd_wr_q   <= 1'b0;
         op_done_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         a_q       <= a_d;
         b_q       <= b_d;
         imm_q     <= imm_d;
         prod_q    <= prod_d;
         mcnt_q    <= mcnt_d;
         tcnt_q    <= tcnt_d;
         res_q     <= res_d;
         carry_q   <= carry_d;
         zero_q    <= zero_d;
         rd_wr_q   <= rd_wr_d;
         op_done_q <= op_done_d;
         err_q     <= err_d;
      end
   end

   assign data_result = res_q;
   assign carry       = carry_q;
   assign zero        = zero_q;
   assign rd_wr       = rd_wr_q;
   assign op_done     = op_done_q;
   assign timeout_err = err_q;
   assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed and random ops
// compared against an arithmetic reference model and a bank model.
module tb_alu_exec_unit;

   localparam int W  = 4;
   localparam int TO = 8;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [7:0]   instr;
   logic [W-1:0] data_A;
   logic [W-1:0] data_B;
   logic         wr_done;
   logic [W-1:0] data_result;
   logic         rd_wr;
   logic         busy;
   logic         op_done;
   logic         carry;
   logic         zero;
   logic         timeout_err;

   int passed = 0;
   int total  = 0;
   bit err_exp = 1'b0;

   alu_exec_unit #(.WIDTH(W), .DONE_TIMEOUT(TO)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .instr      (instr),
      .data_A     (data_A),
      .data_B     (data_B),
      .wr_done    (wr_done),
      .data_result(data_result),
      .rd_wr      (rd_wr),
      .busy       (busy),
      .op_done    (op_done),
      .carry      (carry),
      .zero       (zero),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      total = total + 1;
      assert (obs === exp) passed = passed + 1;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   // Reference: {carry, result} from plain integer arithmetic.
   function automatic int model_res(int op, int a, int b, int imm);
      int m = 1 << W;
      int r;
      case (op)
         0: r = a + b;
         1: r = m - 1 - a;
         2: r = a * 2;
         3: r = a / 2;
         4: r = (a - b + m);
         5: r = a * b;
         6: r = imm;
         default: r = a + 1;
      endcase
      return r % m;
   endfunction

   function automatic int model_c(int op, int a, int b);
      int m = 1 << W;
      case (op)
         0: return (a + b >= m) ? 1 : 0;
         2: return (a >= m / 2) ? 1 : 0;
         3: return a % 2;
         4: return (a < b) ? 1 : 0;
         5: return (a * b >= m) ? 1 : 0;
         7: return (a + 1 >= m) ? 1 : 0;
         default: return 0;
      endcase
   endfunction

   // Launches one op, plays the bank (ack one cycle after rd_wr when
   // ack=1) and checks the outcome and its timing.
   task automatic run_op(input string tag, input int op, input int a,
                         input int b, input int imm, input bit ack,
                         input bit inject);
      int  n_rd = 0, rd_cyc = -1, n_done = 0, done_cyc = -1;
      int  n_busy = 0, err_cyc = -1, res_at_rd = -1;
      bit  prev_rd = 1'b0;
      bit  err0 = err_exp;
      int  er = model_res(op, a, b, imm);
      int  ec = model_c(op, a, b);
      int  lat = (op == 5) ? W + 1 : 2;
      instr  = {op[2:0], 1'b0, imm[3:0]};
      data_A = W'(a);
      data_B = W'(b);
      start  = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int cyc = 1; cyc <= 16; cyc++) begin
         if (inject && cyc == 2) begin
            instr  = 8'h00;
            data_A = W'(1);
            data_B = W'(1);
            start  = 1'b1;
         end else begin
            start = 1'b0;
         end
         if (rd_wr) begin
            n_rd++;
            rd_cyc = cyc;
            res_at_rd = int'(data_result);
         end
         if (op_done) begin
            n_done++;
            done_cyc = cyc;
         end
         if (busy) n_busy++;
         if (timeout_err && !err0 && err_cyc < 0) err_cyc = cyc;
         wr_done = ack && prev_rd;
         prev_rd = rd_wr;
         @(posedge clk);
         #1;
      end
      start   = 1'b0;
      wr_done = 1'b0;
      if (!ack) err_exp = 1'b1;
      chk({tag, ".res"}, int'(data_result), er);
      chk({tag, ".res_at_rd"}, res_at_rd, er);
      chk({tag, ".carry"}, int'(carry), ec);
      chk({tag, ".zero"}, int'(zero), (er == 0) ? 1 : 0);
      chk({tag, ".n_rd"}, n_rd, 1);
      chk({tag, ".rd_cyc"}, rd_cyc, lat);
      chk({tag, ".n_done"}, n_done, ack ? 1 : 0);
      chk({tag, ".done_cyc"}, done_cyc, ack ? lat + 2 : -1);
      chk({tag, ".n_busy"}, n_busy, ack ? lat + 1 : lat + TO);
      chk({tag, ".err"}, int'(timeout_err), int'(err_exp));
      if (!ack && !err0) chk({tag, ".err_cyc"}, err_cyc, lat + TO + 1);
   endtask

   initial begin
      int n_rd;
      reset   = 1'b1;
      start   = 1'b0;
      instr   = 8'h00;
      data_A  = '0;
      data_B  = '0;
      wr_done = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst.busy", int'(busy), 0);
      chk("rst.res", int'(data_result), 0);
      chk("rst.flags", int'({carry, zero, rd_wr, op_done}), 0);
      chk("rst.err", int'(timeout_err), 0);
      reset = 1'b0;

      run_op("add98", 0, 9, 8, 0, 1'b1, 1'b0);
      run_op("mul73", 5, 7, 3, 0, 1'b1, 1'b0);
      run_op("mul09", 5, 0, 9, 0, 1'b1, 1'b0);
      run_op("sub35", 4, 3, 5, 0, 1'b1, 1'b0);
      run_op("incF", 7, 15, 0, 0, 1'b1, 1'b0);
      run_op("mul_inj", 5, 7, 3, 0, 1'b1, 1'b1);
      run_op("tmo", 0, 2, 3, 0, 1'b0, 1'b0);
      run_op("after_tmo", 2, 9, 0, 0, 1'b1, 1'b0);

      for (int i = 0; i < 16; i++) begin
         run_op("rnd", int'($urandom_range(7, 0)),
                int'($urandom_range(15, 0)), int'($urandom_range(15, 0)),
                int'($urandom_range(15, 0)), 1'b1, 1'b0);
      end

      // Reset in the second MUL cycle aborts the op.
      instr  = 8'hA0;
      data_A = W'(7);
      data_B = W'(3);
      start  = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset   = 1'b0;
      err_exp = 1'b0;
      chk("mrst.busy", int'(busy), 0);
      chk("mrst.res", int'(data_result), 0);
      chk("mrst.flags", int'({carry, zero, rd_wr, op_done}), 0);
      chk("mrst.err", int'(timeout_err), 0);
      n_rd = 0;
      for (int c = 0; c < 10; c++) begin
         if (rd_wr) n_rd++;
         @(posedge clk);
         #1;
      end
      chk("mrst.n_rd", n_rd, 0);

      run_op("ldiA", 6, 0, 0, 10, 1'b1, 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
